// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-port synchronous SRAM between the CPU instruction-fetch
// port (i_*) and the CPU data port (d_*). At most one access is granted per
// cycle, read data (1-cycle SRAM latency) is routed back to whichever port
// owned the read, and saturating per-port grant counters are kept for debug.
//
// Optional build macro: SRAM_ARB_STARVE_GUARD_EN
//   Undefined (default): data always wins a contested cycle.
//   Defined: after STARVE_LIMIT consecutive denied fetch cycles, the next
//   contested cycle is forced to the fetch port.
//
// Handshake: a requester raises *_req and holds its address/controls stable
// until it sees *_gnt high in the same cycle. *_gnt is combinational and
// marks the transfer cycle. A granted read returns exactly one cycle later
// with *_rvalid high for one cycle and *_rdata valid only in that cycle.
// Writes produce no response. Dropping *_req before a grant cancels the
// request without side effects.

module sram_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          resetn,

    // instruction fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,

    // data port
    input  logic          d_req,
    input  logic [3:0]    d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    // SRAM side
    output logic          ram_en,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,

    // debug counters
    output logic [31:0]   i_gnt_cnt,
    output logic [31:0]   d_gnt_cnt
);

    // Owner of the read whose data the SRAM presents in the current cycle.
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_INST = 2'd1,
        RSP_DATA = 2'd2
    } rsp_owner_e;

    rsp_owner_e  rsp_owner_q, rsp_owner_d;
    logic [31:0] i_gnt_cnt_q, i_gnt_cnt_d;
    logic [31:0] d_gnt_cnt_q, d_gnt_cnt_d;
    logic        force_fetch;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt_q, starve_cnt_d;

    // Fetch wins a contested cycle once it has been denied STARVE_MAX times.
    always_comb begin
        force_fetch = (starve_cnt_q == STARVE_MAX) && i_req && d_req;
    end

    // Count consecutive denied fetch cycles, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req || i_gnt) begin
            starve_cnt_d = 3'd0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt_q <= 3'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // The limit only matters with the starvation guard; keep it referenced.
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);

    // Fixed data priority: fetch is never forced.
    always_comb begin
        force_fetch = 1'b0;
    end
`endif

    // One grant per cycle; data has priority unless fetch is being forced.
    // Both grants are held low while reset is asserted.
    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (resetn) begin
            d_gnt = d_req && !force_fetch;
            i_gnt = i_req && (!d_req || force_fetch);
        end
    end

    // Steer the granted port onto the SRAM; park everything at zero when idle.
    always_comb begin
        ram_en    = 1'b0;
        ram_wen   = 4'h0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (d_gnt) begin
            ram_en    = 1'b1;
            ram_wen   = d_wen;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end else if (i_gnt) begin
            ram_en    = 1'b1;
            ram_addr  = i_addr;
        end
    end

    // Remember who gets the SRAM read data next cycle; writes return nothing.
    always_comb begin
        rsp_owner_d = RSP_NONE;
        if (d_gnt && (d_wen == 4'h0)) begin
            rsp_owner_d = RSP_DATA;
        end else if (i_gnt) begin
            rsp_owner_d = RSP_INST;
        end
    end

    // Saturating grant counters: stick at all-ones instead of wrapping.
    always_comb begin
        i_gnt_cnt_d = i_gnt_cnt_q;
        d_gnt_cnt_d = d_gnt_cnt_q;
        if (i_gnt && (i_gnt_cnt_q != 32'hFFFF_FFFF)) begin
            i_gnt_cnt_d = i_gnt_cnt_q + 32'd1;
        end
        if (d_gnt && (d_gnt_cnt_q != 32'hFFFF_FFFF)) begin
            d_gnt_cnt_d = d_gnt_cnt_q + 32'd1;
        end
    end

    // Response owner and counter registers; reset drops any pending read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_owner_q <= RSP_NONE;
            i_gnt_cnt_q <= 32'd0;
            d_gnt_cnt_q <= 32'd0;
        end else begin
            rsp_owner_q <= rsp_owner_d;
            i_gnt_cnt_q <= i_gnt_cnt_d;
            d_gnt_cnt_q <= d_gnt_cnt_d;
        end
    end

    // Route SRAM read data to its owner; non-owners see zero.
    always_comb begin
        i_rvalid = (rsp_owner_q == RSP_INST);
        d_rvalid = (rsp_owner_q == RSP_DATA);
        i_rdata  = i_rvalid ? ram_rdata : '0;
        d_rdata  = d_rvalid ? ram_rdata : '0;
    end

    assign i_gnt_cnt = i_gnt_cnt_q;
    assign d_gnt_cnt = d_gnt_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//
// Drives directed scenarios followed by random traffic into sram_port_arbiter
// backed by a behavioural synchronous SRAM. A negedge monitor predicts grants
// and SRAM drive from a reference model, pushes expected read data into
// per-port queues at grant time and pops/compares them when rvalid appears.
// Build with +define+SRAM_ARB_STARVE_GUARD_EN to exercise the starvation guard.

module tb_sram_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic [3:0]    d_wen = 4'h0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          ram_en;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [31:0]   i_gnt_cnt, d_gnt_cnt;

  sram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_wen     (d_wen),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_en    (ram_en),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .i_gnt_cnt (i_gnt_cnt),
    .d_gnt_cnt (d_gnt_cnt)
  );

  // ---------------- behavioural SRAM ----------------
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen == 4'h0) begin
        ram_rdata <= mem[ram_addr[9:0]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_wen[b]) mem[ram_addr[9:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];

  bit mon_en   = 1'b0;
  bit pend_i   = 1'b0;
  bit pend_d   = 1'b0;
  bit now_ig   = 1'b0;
  bit now_dg   = 1'b0;
  bit now_d_rd = 1'b0;
  bit now_ireq = 1'b0;
  int unsigned m_icnt = 0;
  int unsigned m_dcnt = 0;
  int m_starve = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Predict and check this cycle's grant, SRAM drive and responses.
  always @(negedge clk) begin
    if (mon_en) begin
      logic eg_i, eg_d, force_f;
      force_f = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
      force_f = (m_starve == LIM) && i_req && d_req;
`endif
      eg_d = resetn && d_req && !force_f;
      eg_i = resetn && i_req && (!d_req || force_f);

      check("i_gnt", 32'(i_gnt), 32'(eg_i));
      check("d_gnt", 32'(d_gnt), 32'(eg_d));
      check("ram_en", 32'(ram_en), 32'(eg_i | eg_d));
      if (eg_d) begin
        check("ram_addr_d", ram_addr, d_addr);
        check("ram_wen_d", 32'(ram_wen), 32'(d_wen));
        check("ram_wdata_d", ram_wdata, d_wdata);
      end else if (eg_i) begin
        check("ram_addr_i", ram_addr, i_addr);
        check("ram_wen_i", 32'(ram_wen), 32'd0);
        check("ram_wdata_i", ram_wdata, 32'd0);
      end else begin
        check("ram_addr_idle", ram_addr, 32'd0);
        check("ram_wen_idle", 32'(ram_wen), 32'd0);
      end

      check("i_rvalid", 32'(i_rvalid), 32'(pend_i));
      check("d_rvalid", 32'(d_rvalid), 32'(pend_d));
      if (pend_i) begin
        if (i_exp_q.size() == 0) check("i_exp_q_empty", 32'd1, 32'd0);
        else check("i_rdata", i_rdata, i_exp_q.pop_front());
      end else begin
        check("i_rdata_idle", i_rdata, 32'd0);
      end
      if (pend_d) begin
        if (d_exp_q.size() == 0) check("d_exp_q_empty", 32'd1, 32'd0);
        else check("d_rdata", d_rdata, d_exp_q.pop_front());
      end else begin
        check("d_rdata_idle", d_rdata, 32'd0);
      end

      check("i_gnt_cnt", i_gnt_cnt, m_icnt);
      check("d_gnt_cnt", d_gnt_cnt, m_dcnt);

      now_ig   = eg_i;
      now_dg   = eg_d;
      now_d_rd = eg_d && (d_wen == 4'h0);
      now_ireq = i_req;
      if (eg_i) i_exp_q.push_back(ref_mem[i_addr[9:0]]);
      if (eg_d) begin
        if (d_wen == 4'h0) begin
          d_exp_q.push_back(ref_mem[d_addr[9:0]]);
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (d_wen[b]) ref_mem[d_addr[9:0]][b*8 +: 8] = d_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Advance the model at the clock edge; reset drops pending reads.
  always @(posedge clk) begin
    if (mon_en) begin
      if (!resetn) begin
        pend_i = 1'b0;
        pend_d = 1'b0;
        i_exp_q.delete();
        d_exp_q.delete();
        m_icnt = 0;
        m_dcnt = 0;
        m_starve = 0;
      end else begin
        pend_i = now_ig;
        pend_d = now_d_rd;
        if (now_ig) m_icnt++;
        if (now_dg) m_dcnt++;
        if (!now_ireq || now_ig) m_starve = 0;
        else if (m_starve < LIM) m_starve++;
      end
      now_ig   = 1'b0;
      now_dg   = 1'b0;
      now_d_rd = 1'b0;
      now_ireq = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx]     = val;
    ref_mem[idx] = val;
  endtask

  task automatic idle_inputs();
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_wen   = 4'h0;
    d_wdata = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem[k]     = 32'h0;
      ref_mem[k] = 32'h0;
    end
    preload(32'h10, 32'h2402_0005);
    preload(32'h100, 32'hDEAD_BEEF);

    // reset held two cycles, idle, then with a fetch request pending
    resetn = 1'b0;
    cyc();
    mon_en = 1'b1;
    cyc();
    i_req  = 1'b1;
    i_addr = 32'h10;
    cyc();
    resetn = 1'b1;
    i_req  = 1'b0;
    cyc();

    // fetch only
    i_req  = 1'b1;
    i_addr = 32'h10;
    cyc();
    idle_inputs();
    cyc();
    cyc();

    // contention: data read wins, fetch follows once data drops
    i_req  = 1'b1;
    i_addr = 32'h10;
    d_req  = 1'b1;
    d_wen  = 4'h0;
    d_addr = 32'h100;
    cyc();
    d_req = 1'b0;
    cyc();
    idle_inputs();
    cyc();
    cyc();

    // write then read of the same address
    d_req   = 1'b1;
    d_wen   = 4'hF;
    d_addr  = 32'h20;
    d_wdata = 32'h1234_5678;
    cyc();
    d_wen   = 4'h0;
    d_wdata = '0;
    cyc();
    idle_inputs();
    cyc();
    cyc();

    // reset mid-read: fetch granted, reset sampled on the following edge
    i_req  = 1'b1;
    i_addr = 32'h100;
    @(negedge clk);
    #1;
    resetn = 1'b0;
    i_req  = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    cyc();

    // sustained contention (starvation guard when enabled)
    i_req  = 1'b1;
    i_addr = 32'h10;
    d_req  = 1'b1;
    d_wen  = 4'h0;
    d_addr = 32'h20;
    repeat (12) cyc();
    idle_inputs();
    cyc();
    cyc();

    // random traffic, including withdrawn requests and partial writes
    repeat (400) begin
      i_req  = 1'($urandom_range(0, 1));
      i_addr = {22'h0, 6'($urandom_range(0, 63)), 4'h0};
      d_req  = 1'($urandom_range(0, 1));
      d_addr = {22'h0, 6'($urandom_range(0, 63)), 4'h0};
      case ($urandom_range(0, 3))
        0, 1:    d_wen = 4'h0;
        2:       d_wen = 4'hF;
        default: d_wen = 4'($urandom_range(1, 15));
      endcase
      d_wdata = $urandom();
      if ($urandom_range(0, 49) == 0) resetn = 1'b0;
      else resetn = 1'b1;
      cyc();
    end
    resetn = 1'b1;
    idle_inputs();
    repeat (3) cyc();

    if (i_exp_q.size() != 0 || d_exp_q.size() != 0) begin
      check("leftover_responses", 32'(i_exp_q.size() + d_exp_q.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the CPU instruction-fetch port and the CPU data port.
- Sits between the cpu core and the unified memory.
- Grants at most one access per cycle and routes 1-cycle-latency read data back to the owning requester.
- Keeps saturating per-port grant counters for debug.

Parameters:
- AW, 32, address width
- DW, 32, data width (must be 32; byte-lane write enables are 4 bits)
- STARVE_LIMIT, 4, consecutive denied fetch cycles before forced fetch grant (used only with the optional feature)

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch granted this cycle (combinational)
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  DW  fetch read data
- d_req  in  1  data request; held with d_addr/d_wen/d_wdata stable until d_gnt
- d_wen  in  4  byte write enables; 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  data write data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  data read data valid
- d_rdata  out  DW  data read data
- ram_en  out  1  SRAM enable
- ram_wen  out  4  SRAM byte write enables
- ram_addr  out  AW  SRAM address
- ram_wdata  out  DW  SRAM write data
- ram_rdata  in  DW  SRAM read data, valid the cycle after an enabled read
- i_gnt_cnt  out  32  saturating count of fetch grants
- d_gnt_cnt  out  32  saturating count of data grants

Behaviour:
- Reset: while resetn=0 at a rising edge:
  - i_gnt=d_gnt=0 and ram_en=0 (gating is combinational on resetn).
  - Cleared at the edge: rsp_owner=NONE, i_rvalid=d_rvalid=0, i_gnt_cnt=d_gnt_cnt=0, starvation counter=0.
  - i_rdata/d_rdata=0 while their rvalid=0.
- Arbitration (combinational, one grant per cycle):
  - Only d_req -> d_gnt.
  - Only i_req -> i_gnt.
  - Both -> d_gnt (fixed data priority), unless the optional feature forces a fetch grant.
  - Neither -> no grant, ram_en=0.
- SRAM drive:
  - On d_gnt: ram_en=1, ram_wen=d_wen, ram_addr=d_addr, ram_wdata=d_wdata.
  - On i_gnt: ram_en=1, ram_wen=0, ram_addr=i_addr, ram_wdata=0.
  - Otherwise all ram_* = 0.
- Response tracking: registered rsp_owner in {NONE, INST, DATA}. At each edge:
  - DATA if d_gnt and d_wen==0.
  - INST if i_gnt.
  - Else NONE (writes produce no response).
- Read response latency: exactly 1 cycle after grant.
  - rsp_owner==INST -> i_rvalid=1, i_rdata=ram_rdata.
  - rsp_owner==DATA -> d_rvalid=1, d_rdata=ram_rdata.
  - Never both rvalid in the same cycle.
- Back-to-back: a new grant is legal every cycle, including the cycle a prior response is returned. The response of grant N and the request of grant N+1 overlap.
- Write then read of the same address on consecutive grants: the read returns the written data (SRAM write-first ordering across cycles).
- Requester withdraws req before gnt: the request is simply not serviced; no error.
- Grant counters: increment on each own gnt; saturate at 0xFFFF_FFFF (no wrap).
- Reset mid-operation: an outstanding read is dropped. No rvalid is issued in the cycle after the reset edge.

Optional Feature:
- Macro: SRAM_ARB_STARVE_GUARD_EN.
- With the macro: a 3-bit starve_cnt increments each cycle i_req=1 and i_gnt=0 (saturating at STARVE_LIMIT). It clears on i_gnt or i_req=0. When starve_cnt==STARVE_LIMIT and both requests are present, i_gnt wins and d_gnt=0.
- Without the macro: starve_cnt does not exist; data always wins contested cycles (fixed priority).

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, no req -> all outputs 0, counters 0; ram_en=0 while reset held even with i_req=1.
- Fetch only: i_req=1, i_addr=0x0000_0010, SRAM[0x10]=0x2402_0005 -> i_gnt same cycle, next cycle i_rvalid=1, i_rdata=0x2402_0005, i_gnt_cnt=1.
- Contention: i_req=d_req=1 (d read 0x100 holding 0xDEAD_BEEF) -> d_gnt=1, i_gnt=0. Next cycle d_rvalid=1, d_rdata=0xDEAD_BEEF, i_gnt=1 (d_req dropped).
- Write then read: d_wen=4'hF, d_addr=0x20, d_wdata=0x1234_5678; next cycle d_wen=0, same address -> no d_rvalid after the write; d_rdata=0x1234_5678 one cycle after the read grant.
- Reset mid-read: fetch granted, resetn=0 on the following edge -> i_rvalid stays 0; rsp_owner=NONE.
- Starvation guard (macro defined, STARVE_LIMIT=4): d_req and i_req held high continuously -> d_gnt for 4 cycles, i_gnt on the 5th, then d_gnt again. Without the macro: i_gnt never asserts.
